// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares single-port data memory between the CPU port and a debug
//            port using round-robin arbitration with a bounded debug burst lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_wen,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_lock,
    input  logic          dbg_wen,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int                 c_cnt_w   = $clog2(MAX_BURST) + 1;
    localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_BURST);

    typedef enum logic [0:0] {
        ST_RR   = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t             r_st,       w_st_nxt;
    logic               r_last_gnt, w_last_nxt;   // 1 = debug was granted last
    logic [c_cnt_w-1:0] r_cnt,      w_cnt_nxt;
    logic               w_cpu_gnt,  w_dbg_gnt;
    logic               r_cpu_rvalid, r_dbg_rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st         <= ST_RR;
            r_last_gnt   <= 1'b1;
            r_cnt        <= '0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
        end else begin
            r_st         <= w_st_nxt;
            r_last_gnt   <= w_last_nxt;
            r_cnt        <= w_cnt_nxt;
            r_cpu_rvalid <= w_cpu_gnt & ~cpu_wen;
            r_dbg_rvalid <= w_dbg_gnt & ~dbg_wen;
        end
    end

    always_comb begin
        w_cpu_gnt  = 1'b0;
        w_dbg_gnt  = 1'b0;
        w_st_nxt   = r_st;
        w_last_nxt = r_last_gnt;
        w_cnt_nxt  = r_cnt;
        if (r_st == ST_LOCK && dbg_req && dbg_lock) begin
            if (cpu_req && r_cnt == c_max_cnt) begin
                // Burst budget spent while the CPU waits: break the lock.
                w_cpu_gnt  = 1'b1;
                w_st_nxt   = ST_RR;
                w_cnt_nxt  = '0;
                w_last_nxt = 1'b0;
            end else begin
                w_dbg_gnt  = 1'b1;
                w_last_nxt = 1'b1;
                if (cpu_req) begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
        end else begin
            w_st_nxt  = ST_RR;
            w_cnt_nxt = '0;
            if (cpu_req && (!dbg_req || r_last_gnt)) begin
                w_cpu_gnt  = 1'b1;
                w_last_nxt = 1'b0;
            end else if (dbg_req) begin
                w_dbg_gnt  = 1'b1;
                w_last_nxt = 1'b1;
                if (dbg_lock) begin
                    w_st_nxt  = ST_LOCK;
                    w_cnt_nxt = c_cnt_w'(1);
                end
            end
        end
    end

    always_comb begin
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_gnt) begin
            mem_wen   = cpu_wen;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_dbg_gnt) begin
            mem_wen   = dbg_wen;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    assign cpu_gnt    = w_cpu_gnt;
    assign dbg_gnt    = w_dbg_gnt;
    assign cpu_stall  = cpu_req & ~w_cpu_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign dbg_rvalid = r_dbg_rvalid;
    assign cpu_rdata  = r_cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = r_dbg_rvalid ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Scoreboard bench for dmem_arbiter with a 1-cycle-latency memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_wen, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_lock, dbg_wen, dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_wen(dbg_wen), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: word-addressed, registered read data
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr[9:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[9:2]];
    end

    typedef struct {
        int          cyc;
        logic        cg, dg, stall, mwen;
        logic [31:0] maddr, mwd;
    } gexp_t;
    typedef struct {
        int          cyc;
        logic [31:0] d;
    } rexp_t;

    gexp_t gq[$];
    rexp_t cq[$];
    rexp_t dq[$];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic en = 1'b0;
    logic no_ret = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares against scoreboard entries due in the current cycle
    always @(negedge clk) begin
        if (en) begin
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                gexp_t g;
                g = gq.pop_front();
                chk("cpu_gnt",   {31'd0, cpu_gnt},   {31'd0, g.cg});
                chk("dbg_gnt",   {31'd0, dbg_gnt},   {31'd0, g.dg});
                chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, g.stall});
                chk("mem_wen",   {31'd0, mem_wen},   {31'd0, g.mwen});
                chk("mem_addr",  mem_addr,  g.maddr);
                chk("mem_wdata", mem_wdata, g.mwd);
            end
            if (cq.size() > 0 && cq[0].cyc == cyc) begin
                rexp_t r;
                r = cq.pop_front();
                chk("cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
                chk("cpu_rdata",  cpu_rdata, r.d);
            end else begin
                chk("cpu_rvalid_idle", {31'd0, cpu_rvalid}, 32'd0);
                chk("cpu_rdata_idle",  cpu_rdata, 32'd0);
            end
            if (dq.size() > 0 && dq[0].cyc == cyc) begin
                rexp_t r;
                r = dq.pop_front();
                chk("dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
                chk("dbg_rdata",  dbg_rdata, r.d);
            end else begin
                chk("dbg_rvalid_idle", {31'd0, dbg_rvalid}, 32'd0);
                chk("dbg_rdata_idle",  dbg_rdata, 32'd0);
            end
        end
    end

    // Drive one cycle of requests and record the hand-computed outcome
    task automatic step(
        input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
        input logic dr, input logic dl, input logic dw, input logic [31:0] da, input logic [31:0] dd,
        input logic ecg, input logic edg, input logic [31:0] ecr, input logic [31:0] edr);
        gexp_t g;
        cpu_req = cr; cpu_wen = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_lock = dl; dbg_wen = dw; dbg_addr = da; dbg_wdata = dd;
        g.cyc = cyc; g.cg = ecg; g.dg = edg; g.stall = cr & ~ecg;
        g.mwen = 1'b0; g.maddr = 32'd0; g.mwd = 32'd0;
        if (ecg) begin
            g.mwen = cw; g.maddr = ca; g.mwd = cd;
        end else if (edg) begin
            g.mwen = dw; g.maddr = da; g.mwd = dd;
        end
        gq.push_back(g);
        if (ecg && !cw && !no_ret) cq.push_back('{cyc + 1, ecr});
        if (edg && !dw && !no_ret) dq.push_back('{cyc + 1, edr});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[4] = 32'hDEADBEEF;  // 0x10
        mem[8] = 32'h1111_0000; // 0x20
        rst = 1'b1;
        cpu_req = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_lock = 0; dbg_wen = 0; dbg_addr = 0; dbg_wdata = 0;
        @(posedge clk);
        #1;
        en = 1'b1;
        idle();                       // reset cycle: no grants, no rvalid
        rst = 1'b0;

        // 1: single CPU read
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0);
        idle();
        // debug-only read sets last grant to debug
        step(0, 0, 0, 0, 1, 0, 0, 32'h10, 0, 0, 1, 0, 32'hDEADBEEF);

        // 2: both request every cycle, no lock -> C,D,C,D,C,D
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, 1, 0, 32'hDEADBEEF, 0);
            step(1, 0, 32'h14, 0, 1, 0, 0, 32'h20, 0, 0, 1, 0, 32'h1111_0000);
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        // 3: same-cycle dbg write / cpu read of 0x20, then re-read
        step(1, 0, 32'h20, 0, 1, 0, 1, 32'h20, 32'h1234, 1, 0, 32'h1111_0000, 0);
        step(0, 0, 0, 0, 1, 0, 1, 32'h20, 32'h1234, 0, 1, 0, 0);
        step(1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1234, 0);

        // 4: locked burst with CPU waiting from cycle 1 -> 8 dbg grants, then cpu
        step(0, 0, 0, 0, 1, 1, 0, 32'h20, 0, 0, 1, 0, 32'h1234);
        for (int i = 0; i < 7; i++)
            step(1, 0, 32'h10, 0, 1, 1, 0, 32'h20, 0, 0, 1, 0, 32'h1234);
        step(1, 0, 32'h10, 0, 1, 1, 0, 32'h20, 0, 1, 0, 32'hDEADBEEF, 0);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 32'h20, 0, 1, 0, 0, 32'h10, 0, 0, 1, 0, 32'hDEADBEEF);
            step(1, 0, 32'h20, 0, 1, 0, 0, 32'h10, 0, 1, 0, 32'h1234, 0);
        end
        idle();

        // 5: long lock with CPU idle, then CPU arrives -> 7 more dbg grants
        for (int i = 0; i < 20; i++)
            step(0, 0, 0, 0, 1, 1, 0, 32'h10, 0, 0, 1, 0, 32'hDEADBEEF);
        for (int i = 0; i < 7; i++)
            step(1, 1, 32'h30, 32'hCAFE, 1, 1, 0, 32'h10, 0, 0, 1, 0, 32'hDEADBEEF);
        step(1, 1, 32'h30, 32'hCAFE, 1, 1, 0, 32'h10, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 32'h30, 0, 0, 1, 0, 32'hCAFE);
        idle();

        // 6: dbg read granted in a reset cycle returns nothing; cpu wins next
        step(0, 0, 0, 0, 1, 1, 0, 32'h10, 0, 0, 1, 0, 32'hDEADBEEF);
        rst = 1'b1;
        no_ret = 1'b1;
        step(0, 0, 0, 0, 1, 1, 0, 32'h20, 0, 0, 1, 0, 0);
        rst = 1'b0;
        no_ret = 1'b0;
        step(1, 0, 32'h10, 0, 1, 1, 0, 32'h20, 0, 1, 0, 32'hDEADBEEF, 0);
        step(0, 0, 0, 0, 1, 1, 0, 32'h20, 0, 0, 1, 0, 32'h1234);
        idle();
        idle();

        chk("gnt_queue_drained", gq.size(), 32'd0);
        chk("cpu_queue_drained", cq.size(), 32'd0);
        chk("dbg_queue_drained", dq.size(), 32'd0);
        en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
